riscv_multicycle_ctrl: RTL

//  Moore FSM sequencer for the multi-cycle RV32I datapath. Fetches through imem, decodes
//  the opcode, drives op2_sel (OP2_SEL enum: OP2_RS2/OP2_IMI/OP2_IMS/OP2_IMJ) into the
//  ALU operand-2 mux, handshakes dmem, and emits IR/RF/PC write strobes plus a retire count.

---
 rtl/riscv_multicycle_ctrl.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/riscv_multicycle_ctrl.sv
// Multi-cycle RV32I control sequencer: fetch/decode/exec/mem/wb FSM with
// operand-2 select, memory handshakes, write strobes and a retire counter.
// ir_we is a registered strobe: it is high in the DECODE cycle that follows the
// accepted fetch, and the opcode is captured internally on the accepting edge.

package riscv_multicycle_ctrl_pkg;
    typedef enum logic [1:0] {
        OP2_RS2 = 2'd0,
        OP2_IMI = 2'd1,
        OP2_IMS = 2'd2,
        OP2_IMJ = 2'd3
    } op2_sel_e;
endpackage

module riscv_multicycle_ctrl
    import riscv_multicycle_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic             imem_req,
    input  logic             imem_rvalid,
    input  logic [31:0]      instr,
    output logic             dmem_req,
    output logic             dmem_we,
    input  logic             dmem_ack,
    output logic             ir_we,
    output op2_sel_e         op2_sel,
    output logic             rf_we,
    output logic             pc_we,
    output logic [CNT_W-1:0] instret,
    output logic             trap,
    output logic [1:0]       trap_cause
);

    localparam int unsigned TMO_W = $clog2(MEM_TIMEOUT + 1);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
    localparam logic [1:0] CAUSE_DMEM_TO = 2'b10;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_TRAP   = 3'd5
    } state_e;

    state_e           st_q, st_d;
    logic [6:0]       opc_q, opc_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    op2_sel_e         op2_d;
    logic [1:0]       cause_d;
    logic [CNT_W-1:0] instret_d;
    logic             ir_we_d, dmem_req_d, dmem_we_d, rf_we_d, pc_we_d, trap_d;
    logic             is_store, is_mem;
    logic             unused_instr;

    assign unused_instr = ^instr[31:7];
    assign is_store     = (opc_q == OPC_STORE);
    assign is_mem       = is_store || (opc_q == OPC_LOAD);

    // Fetch request follows the state register directly so the first fetch after
    // reset is not delayed a cycle; rst_n masks it while reset is held.
    assign imem_req = (st_q == ST_FETCH) && rst_n;

    // Next-state, next-output and bookkeeping decode.
    always_comb begin
        st_d      = st_q;
        opc_d     = opc_q;
        tmo_d     = tmo_q;
        op2_d     = op2_sel;
        cause_d   = trap_cause;
        instret_d = instret;

        case (st_q)
            ST_FETCH: begin
                if (imem_rvalid) begin
                    st_d  = ST_DECODE;
                    opc_d = instr[6:0];
                end
            end
            ST_DECODE: begin
                st_d = ST_EXEC;
                case (opc_q)
                    OPC_OP:                       op2_d = OP2_RS2;
                    OPC_OP_IMM, OPC_LOAD, OPC_JALR: op2_d = OP2_IMI;
                    OPC_STORE:                    op2_d = OP2_IMS;
                    OPC_JAL:                      op2_d = OP2_IMJ;
                    default: begin
                        st_d    = ST_TRAP;
                        cause_d = CAUSE_ILLEGAL;
                    end
                endcase
            end
            ST_EXEC: begin
                if (is_mem) begin
                    st_d  = ST_MEM;
                    tmo_d = '0;
                end else begin
                    st_d = ST_WB;
                end
            end
            ST_MEM: begin
                if (dmem_ack) begin
                    st_d = ST_WB;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                    if (tmo_q == TMO_W'(MEM_TIMEOUT - 1)) begin
                        st_d    = ST_TRAP;
                        cause_d = CAUSE_DMEM_TO;
                    end
                end
            end
            ST_WB:   st_d = ST_FETCH;
            ST_TRAP: st_d = ST_TRAP;
            default: st_d = ST_FETCH;
        endcase

        if (st_d == ST_WB) begin
            instret_d = instret + CNT_W'(1);
        end

        ir_we_d    = (st_d == ST_DECODE);
        dmem_req_d = (st_d == ST_MEM);
        dmem_we_d  = (st_d == ST_MEM) && is_store;
        rf_we_d    = (st_d == ST_WB) && !is_store;
        pc_we_d    = (st_d == ST_WB);
        trap_d     = (st_d == ST_TRAP);
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q       <= ST_FETCH;
            opc_q      <= '0;
            tmo_q      <= '0;
            op2_sel    <= OP2_RS2;
            trap_cause <= '0;
            instret    <= '0;
            ir_we      <= 1'b0;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            rf_we      <= 1'b0;
            pc_we      <= 1'b0;
            trap       <= 1'b0;
        end else begin
            st_q       <= st_d;
            opc_q      <= opc_d;
            tmo_q      <= tmo_d;
            op2_sel    <= op2_d;
            trap_cause <= cause_d;
            instret    <= instret_d;
            ir_we      <= ir_we_d;
            dmem_req   <= dmem_req_d;
            dmem_we    <= dmem_we_d;
            rf_we      <= rf_we_d;
            pc_we      <= pc_we_d;
            trap       <= trap_d;
        end
    end

endmodule
